// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data ports; data wins ties.
// Latency: request seen in IDLE -> mem_req next cycle -> ready one cycle after mem_ack (min 2).
// Backpressure: requester holds req until its ready pulse; pipeline is held via stall/flush meanwhile.
module mem_port_arbiter #(
    parameter logic [2:0]  FETCH_MODE = 3'b010,
    parameter int          TIMEOUT    = 16,
    parameter logic [31:0] ERR_DATA   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_adrs,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_mode,
    input  logic [31:0] d_adrs,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_req,
    output logic [31:0] mem_adrs,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    output logic [2:0]  mem_mode,
    input  logic [31:0] mem_rd,
    input  logic        mem_ack,
    output logic        bus_err,
    output logic        stall_F,
    output logic        stall_D,
    output logic        stall_E,
    output logic        stall_M,
    output logic        flush_D,
    output logic        flush_WB
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, D_BUSY, D_RESP, F_BUSY, F_RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] mem_adrs_q, mem_adrs_d;
    logic [31:0] mem_wd_q, mem_wd_d;
    logic        mem_we_q, mem_we_d;
    logic [2:0]  mem_mode_q, mem_mode_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        busy, done, data_pend, fetch_pend;
    logic [31:0] resp_data;

    always_comb begin
        state_d    = state_q;
        mem_adrs_d = mem_adrs_q;
        mem_wd_d   = mem_wd_q;
        mem_we_d   = mem_we_q;
        mem_mode_d = mem_mode_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        cnt_d      = '0;
        err_d      = 1'b0;
        busy       = (state_q == D_BUSY) || (state_q == F_BUSY);
        // An ack on the final counted cycle still wins over the timeout.
        done       = mem_ack || (cnt_q == CW'(TIMEOUT - 1));
        resp_data  = mem_ack ? mem_rd : ERR_DATA;

        case (state_q)
            IDLE: begin
                if (d_req) begin
                    state_d    = D_BUSY;
                    mem_adrs_d = d_adrs;
                    mem_wd_d   = d_wdata;
                    mem_we_d   = d_we;
                    mem_mode_d = d_mode;
                end else if (if_req) begin
                    state_d    = F_BUSY;
                    mem_adrs_d = if_adrs;
                    mem_wd_d   = '0;
                    mem_we_d   = 1'b0;
                    mem_mode_d = FETCH_MODE;
                end
            end
            D_BUSY, F_BUSY: begin
                if (done) begin
                    state_d  = (state_q == D_BUSY) ? D_RESP : F_RESP;
                    mem_we_d = 1'b0;
                    err_d    = !mem_ack;
                    if (state_q == D_BUSY) d_rdata_d = resp_data;
                    else                   if_rdata_d = resp_data;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mem_adrs_q <= '0;
            mem_wd_q   <= '0;
            mem_we_q   <= 1'b0;
            mem_mode_q <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_adrs_q <= mem_adrs_d;
            mem_wd_q   <= mem_wd_d;
            mem_we_q   <= mem_we_d;
            mem_mode_q <= mem_mode_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    // Stalls are held low while reset is asserted so the pipeline is not frozen by a live req.
    assign data_pend  = !reset && (((state_q == IDLE) && d_req) || (state_q == D_BUSY));
    assign fetch_pend = !reset && (((state_q == IDLE) && if_req && !d_req) ||
                                   (state_q == F_BUSY) ||
                                   ((state_q == D_RESP) && if_req));

    assign mem_req  = busy;
    assign mem_adrs = mem_adrs_q;
    assign mem_wd   = mem_wd_q;
    assign mem_we   = mem_we_q;
    assign mem_mode = mem_mode_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign if_ready = (state_q == F_RESP);
    assign d_ready  = (state_q == D_RESP);
    assign bus_err  = err_q;

    assign stall_F  = data_pend || fetch_pend;
    assign stall_D  = data_pend;
    assign stall_E  = data_pend;
    assign stall_M  = data_pend;
    assign flush_WB = data_pend;
    assign flush_D  = fetch_pend && !data_pend;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised self-checking bench for mem_port_arbiter: the bench plays both requesters and the memory.
module tb_mem_port_arbiter;
    localparam int          TIMEOUT = 16;
    localparam logic [2:0]  FMODE   = 3'b010;
    localparam logic [31:0] ERRD    = 32'h0000_0013;

    logic        clk, reset;
    logic        if_req, if_ready, d_req, d_we, d_ready;
    logic [31:0] if_adrs, if_rdata, d_adrs, d_wdata, d_rdata;
    logic [2:0]  d_mode, mem_mode;
    logic        mem_req, mem_we, mem_ack, bus_err;
    logic [31:0] mem_adrs, mem_wd, mem_rd;
    logic        stall_F, stall_D, stall_E, stall_M, flush_D, flush_WB;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_d = '0, last_f = '0;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_adrs(if_adrs), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_mode(d_mode), .d_adrs(d_adrs), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_adrs(mem_adrs), .mem_wd(mem_wd), .mem_we(mem_we),
        .mem_mode(mem_mode), .mem_rd(mem_rd), .mem_ack(mem_ack), .bus_err(bus_err),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_D(flush_D), .flush_WB(flush_WB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One access from the IDLE cycle it is presented in, through its RESP cycle.
    // delay = index of the BUSY cycle carrying mem_ack; >= TIMEOUT means never acked.
    task automatic run_access(input bit is_d, input bit hold_f, input logic we,
                              input logic [2:0] mode, input logic [31:0] adrs,
                              input logic [31:0] wdata, input logic [31:0] rd, input int delay);
        bit to, busy, resp, pend_d, pend_f, ack_now;
        int b;
        logic [31:0] exp_rd, exp_d, exp_f;
        to     = (delay >= TIMEOUT);
        b      = to ? TIMEOUT : delay + 1;
        exp_rd = to ? ERRD : rd;
        if (is_d) begin
            d_req = 1; d_we = we; d_mode = mode; d_adrs = adrs; d_wdata = wdata;
            if_req = hold_f; if_adrs = $urandom;
        end else begin
            if_req = 1; if_adrs = adrs;
            d_req = 0; d_we = $urandom_range(1, 0); d_adrs = $urandom; d_wdata = $urandom;
        end
        for (int c = 0; c <= b + 1; c++) begin
            busy    = (c >= 1) && (c <= b);
            resp    = (c == b + 1);
            ack_now = busy && (c == delay + 1);
            mem_ack = ack_now || (!busy && ($urandom_range(1, 0) == 1));
            mem_rd  = ack_now ? rd : $urandom;
            pend_d  = is_d && (c <= b);
            pend_f  = (!is_d && (c <= b)) || (is_d && hold_f && resp);
            exp_d   = (is_d && resp) ? exp_rd : last_d;
            exp_f   = (!is_d && resp) ? exp_rd : last_f;
            @(negedge clk);
            total++; if (mem_req !== busy) begin bad++; $display("FAIL mem_req c=%0d: got %b want %b", c, mem_req, busy); end
            if (busy) begin
                total++; if (mem_adrs !== adrs) begin bad++; $display("FAIL mem_adrs c=%0d: got %h want %h", c, mem_adrs, adrs); end
                total++; if (mem_we !== (is_d ? we : 1'b0)) begin bad++; $display("FAIL mem_we c=%0d: got %b want %b", c, mem_we, is_d ? we : 1'b0); end
                total++; if (mem_mode !== (is_d ? mode : FMODE)) begin bad++; $display("FAIL mem_mode c=%0d: got %b want %b", c, mem_mode, is_d ? mode : FMODE); end
                total++; if (mem_wd !== (is_d ? wdata : 32'h0)) begin bad++; $display("FAIL mem_wd c=%0d: got %h want %h", c, mem_wd, is_d ? wdata : 32'h0); end
            end
            if (resp) begin
                total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL mem_we_resp: got %b want 0", mem_we); end
            end
            total++; if (d_ready !== (is_d && resp)) begin bad++; $display("FAIL d_ready c=%0d: got %b want %b", c, d_ready, is_d && resp); end
            total++; if (if_ready !== (!is_d && resp)) begin bad++; $display("FAIL if_ready c=%0d: got %b want %b", c, if_ready, !is_d && resp); end
            total++; if (bus_err !== (resp && to)) begin bad++; $display("FAIL bus_err c=%0d: got %b want %b", c, bus_err, resp && to); end
            total++; if (d_rdata !== exp_d) begin bad++; $display("FAIL d_rdata c=%0d: got %h want %h", c, d_rdata, exp_d); end
            total++; if (if_rdata !== exp_f) begin bad++; $display("FAIL if_rdata c=%0d: got %h want %h", c, if_rdata, exp_f); end
            total++;
            if ({stall_F, stall_D, stall_E, stall_M, flush_WB, flush_D} !==
                {pend_d || pend_f, pend_d, pend_d, pend_d, pend_d, pend_f && !pend_d}) begin
                bad++;
                $display("FAIL stalls c=%0d: got F%b D%b E%b M%b WB%b fD%b want d_pend=%b f_pend=%b",
                         c, stall_F, stall_D, stall_E, stall_M, flush_WB, flush_D, pend_d, pend_f);
            end
            @(posedge clk); #1;
        end
        last_d = exp_d;
        last_f = exp_f;
        if (is_d) d_req = 0; else if_req = 0;
        mem_ack = 0;
    endtask

    task automatic idle_cycles(input int n, input bit force_ack);
        d_req = 0; if_req = 0;
        for (int i = 0; i < n; i++) begin
            mem_ack = force_ack || ($urandom_range(1, 0) == 1);
            mem_rd  = $urandom;
            @(negedge clk);
            total++; if ({mem_req, d_ready, if_ready, bus_err} !== 4'b0) begin bad++; $display("FAIL idle_out: got req%b dr%b ir%b err%b want 0", mem_req, d_ready, if_ready, bus_err); end
            total++; if ({stall_F, stall_D, stall_E, stall_M, flush_D, flush_WB} !== 6'b0) begin bad++; $display("FAIL idle_stall: got %b want 0", {stall_F, stall_D, stall_E, stall_M, flush_D, flush_WB}); end
            total++; if (d_rdata !== last_d || if_rdata !== last_f) begin bad++; $display("FAIL idle_hold: got d=%h f=%h want d=%h f=%h", d_rdata, if_rdata, last_d, last_f); end
            @(posedge clk); #1;
        end
        mem_ack = 0;
    endtask

    task automatic test_reset();
        repeat (3) begin
            @(negedge clk);
            total++; if ({mem_req, if_ready, d_ready, bus_err} !== 4'b0) begin bad++; $display("FAIL reset_out: got req%b ir%b dr%b err%b want 0", mem_req, if_ready, d_ready, bus_err); end
            total++; if ({stall_F, stall_D, stall_E, stall_M, flush_D, flush_WB} !== 6'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", {stall_F, stall_D, stall_E, stall_M, flush_D, flush_WB}); end
            total++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got f=%h d=%h want 0", if_rdata, d_rdata); end
        end
        @(posedge clk); #1;
        reset = 0;
        run_access(0, 0, 0, 3'b0, 32'h0, 32'h0, 32'h0050_0093, 0);
    endtask

    task automatic test_priority();
        run_access(1, 1, 0, 3'b010, 32'h100, $urandom, 32'hDEAD_BEEF, 2);
        run_access(0, 0, 0, 3'b0, 32'h104, 32'h0, 32'h1234_5678, 0);
    endtask

    task automatic test_store();
        run_access(1, 0, 1, 3'b000, 32'h20, 32'h0000_00AB, $urandom, 1);
        idle_cycles(1, 0);
    endtask

    task automatic test_timeout();
        run_access(0, 0, 0, 3'b0, 32'h200, 32'h0, 32'hCAFE_0001, 99);
        run_access(1, 0, 0, 3'b101, 32'h300, 32'h0, 32'hCAFE_0002, TIMEOUT - 1);
        run_access(1, 0, 1, 3'b001, 32'h304, 32'h55, 32'hCAFE_0003, TIMEOUT);
    endtask

    task automatic test_stray_ack();
        idle_cycles(4, 1);
    endtask

    task automatic test_random();
        bit is_d, hold, prev_hold;
        int r, delay;
        prev_hold = 0;
        for (int i = 0; i < 30; i++) begin
            is_d  = prev_hold ? 1'b0 : bit'($urandom_range(1, 0));
            r     = $urandom_range(7, 0);
            delay = (r < 5) ? r : ((r == 5) ? TIMEOUT - 1 : TIMEOUT + r);
            hold  = is_d && (i < 29) && ($urandom_range(1, 0) == 1);
            run_access(is_d, hold, bit'($urandom_range(1, 0)), 3'($urandom_range(7, 0)),
                       $urandom, $urandom, $urandom, delay);
            prev_hold = hold;
            if (!hold && ($urandom_range(1, 0) == 1)) idle_cycles(1, 0);
        end
    endtask

    task automatic test_reset_mid();
        d_req = 1; d_we = 0; d_mode = 3'b010; d_adrs = 32'h40; d_wdata = 32'h0; if_req = 0;
        mem_ack = 0;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rmid_busy: got %b want 1", mem_req); end
        @(posedge clk); #1;
        reset = 1; d_req = 0;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rmid_req: got %b want 0", mem_req); end
        total++; if ({stall_F, stall_D, stall_E, stall_M, flush_D, flush_WB} !== 6'b0) begin bad++; $display("FAIL rmid_stall: got %b want 0", {stall_F, stall_D, stall_E, stall_M, flush_D, flush_WB}); end
        total++; if (d_ready !== 1'b0 || d_rdata !== 32'h0) begin bad++; $display("FAIL rmid_rdata: got rdy%b %h want 0", d_ready, d_rdata); end
        @(posedge clk); #1;
        reset = 0;
        last_d = '0; last_f = '0;
        idle_cycles(4, 1);
    endtask

    initial begin
        reset = 1; if_req = 1; if_adrs = 32'h0;
        d_req = 0; d_we = 0; d_mode = 3'b0; d_adrs = 32'h0; d_wdata = 32'h0;
        mem_ack = 0; mem_rd = 32'h0;
        test_reset();
        test_priority();
        test_store();
        test_timeout();
        test_stray_ack();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
